// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS CPU: sequences fetch/decode/execute/
// memory/writeback and drives Moore-decoded datapath selects, enables and strobes.
module multicycle_ctrl_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] i_opcode,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_source,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if      (i_opcode == OP_LW || i_opcode == OP_SW) state_d = S_MEM_ADDR;
                else if (i_opcode == OP_RTYPE)                   state_d = S_R_EXEC;
                else if (i_opcode == OP_BEQ)                     state_d = S_BRANCH;
                else if (i_opcode == OP_J)                       state_d = S_JUMP;
                else if (i_opcode == OP_ADDI)                    state_d = S_ADDI_EXEC;
                else                                             state_d = S_FETCH;
            end
            // IR is only loaded in FETCH, so the opcode is still the one decoded.
            S_MEM_ADDR:  state_d = (i_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = 2'd0;
        o_alu_op        = 2'd0;
        o_pc_source     = 2'd0;
        case (state_q)
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_ir_write  = 1'b1;
                o_alu_src_b = 2'd1;
                o_pc_write  = 1'b1;
            end
            S_DECODE:   o_alu_src_b = 2'd3;
            S_MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'd2;
            end
            S_MEM_READ: begin
                o_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                o_mem_write = 1'b1;
                o_iord      = 1'b1;
            end
            S_R_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = 2'd2;
            end
            S_R_WB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = 2'd1;
                o_pc_write_cond = 1'b1;
                o_pc_source     = 2'd1;
            end
            S_JUMP: begin
                o_pc_write  = 1'b1;
                o_pc_source = 2'd2;
            end
            S_ADDI_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'd2;
            end
            S_ADDI_WB:  o_reg_write = 1'b1;
            default: ;
        endcase
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: the driver pushes the expected per-cycle
// output vector for each instruction; a negedge monitor pops and compares.
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       reset_n;
    logic [5:0] i_opcode;
    logic       o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write;
    logic       o_ir_write, o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a;
    logic [1:0] o_alu_src_b, o_alu_op, o_pc_source;
    logic [3:0] o_state;

    localparam int W = 20;
    logic [W-1:0] exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    bit  mon_en   = 1'b0;

    multicycle_ctrl_fsm dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_opcode        (i_opcode),
        .o_pc_write      (o_pc_write),
        .o_pc_write_cond (o_pc_write_cond),
        .o_iord          (o_iord),
        .o_mem_read      (o_mem_read),
        .o_mem_write     (o_mem_write),
        .o_ir_write      (o_ir_write),
        .o_mem_to_reg    (o_mem_to_reg),
        .o_reg_dst       (o_reg_dst),
        .o_reg_write     (o_reg_write),
        .o_alu_src_a     (o_alu_src_a),
        .o_alu_src_b     (o_alu_src_b),
        .o_alu_op        (o_alu_op),
        .o_pc_source     (o_pc_source),
        .o_state         (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: state, pc_write, pc_write_cond, iord, mem_read, mem_write,
    // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
    function automatic logic [W-1:0] exp_vec(input int s);
        case (s)
            0:  return {4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0};
            1:  return {4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0};
            2:  return {4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0};
            3:  return {4'd3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0};
            4:  return {4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0};
            5:  return {4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0};
            6:  return {4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 2'd0};
            7:  return {4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0};
            8:  return {4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd1};
            9:  return {4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2};
            10: return {4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0};
            11: return {4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0};
            default: return '0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after the edge that entered FETCH; returns likewise.
    task automatic run_instr(input logic [5:0] op, input int n, input logic [47:0] states);
        i_opcode = op;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_vec(int'(states[4*i +: 4])));
            step();
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] act, exp_v;
        cyc++;
        if (mon_en) begin
            act = {o_state, o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write,
                   o_ir_write, o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a,
                   o_alu_src_b, o_alu_op, o_pc_source};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL cyc%0d queue_underflow: got %h with nothing expected", cyc, act);
            end else begin
                exp_v = exp_q.pop_front();
                if (act === exp_v) n_pass++;
                else $display("FAIL cyc%0d ctrl_vector: got %h (state %0d) expected %h (state %0d)",
                              cyc, act, act[19:16], exp_v, exp_v[19:16]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        i_opcode = 6'h00;
        step();
        step();
        reset_n = 1'b1;
        mon_en  = 1'b1;
        // Nibble lists are read LSB-first: state sequence per instruction.
        run_instr(6'h23, 5, 48'h43210);      // LW: 0,1,2,3,4 (first cycle checks reset values)
        run_instr(6'h2B, 4, 48'h5210);       // SW
        run_instr(6'h00, 4, 48'h7610);       // R-type back-to-back
        run_instr(6'h04, 3, 48'h810);        // BEQ
        run_instr(6'h02, 3, 48'h910);        // J
        run_instr(6'h3F, 2, 48'h10);         // illegal opcode
        run_instr(6'h08, 4, 48'hBA10);       // ADDI
        run_instr(6'h11, 2, 48'h10);         // another illegal opcode
        // Reset while LW is in MEM_READ: the next state is FETCH, MEM_WB is skipped.
        run_instr(6'h23, 3, 48'h210);
        exp_q.push_back(exp_vec(3));
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        run_instr(6'h00, 4, 48'h7610);
        run_instr(6'h2B, 4, 48'h5210);
        mon_en = 1'b0;
        step();
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
